// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S receive path.
//   state_t    : lock state of the frame tracker (HUNT until the first WS edge).
//   i2s_pair_t : stereo pair at the default 16-bit word width, for consumers
//                such as the register readback path.
//   CH_LEFT    : WS level that denotes the left channel.
package i2s_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  localparam int PAIR_W = 16;

  typedef struct packed {
    logic [PAIR_W-1:0] left;
    logic [PAIR_W-1:0] right;
  } i2s_pair_t;

  localparam logic CH_LEFT = 1'b0;

endpackage

// File: rtl/i2s_input_sync.sv
// i2s_input_sync: brings the asynchronous SCK/WS/SD pins into the fabric
// clock domain and marks each SCK rising edge.
//   clock, reset   : fabric clock, async active-high reset
//   sck_i/ws_i/sd_i: raw pins
//   sck_rise_o     : one-cycle pulse per synchronized SCK rising edge
//   ws_now_o       : WS captured at that edge (held until the next one)
//   sd_now_o       : SD captured at that edge (held until the next one)
module i2s_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sck_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic sck_rise_o,
  output logic ws_now_o,
  output logic sd_now_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
  logic sck_s, ws_s, sd_s;
  logic sck_prev_q;
  logic rise;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign ws_s  = ws_sync_q[SYNC_STAGES-1];
  assign sd_s  = sd_sync_q[SYNC_STAGES-1];
  assign rise  = sck_s & ~sck_prev_q;

  // All three pins share the same chain depth, so WS/SD stay aligned with SCK.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      sck_rise_o <= 1'b0;
      ws_now_o   <= 1'b0;
      sd_now_o   <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws_i};
      sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd_i};
      sck_prev_q <= sck_s;
      sck_rise_o <= rise;
      if (rise) begin
        ws_now_o <= ws_s;
        sd_now_o <= sd_s;
      end
    end
  end

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: Philips-I2S deserializer with valid/ready pair output.
//   clock, reset              : fabric clock (>= 4x SCK), async active-high reset
//   i2s_sck/i2s_ws/i2s_sd     : asynchronous I2S pins (WS 0 = left)
//   sample_valid/sample_ready : pair handshake
//   sample_left/sample_right  : MSB-first, left-justified words
//   slot_bits                 : bit count of last completed slot (saturating)
//   locked                    : frame tracker is in SYNC
//   overflow/overflow_clear   : sticky pair-dropped flag and its clear
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i2s_sck,
  input  logic                    i2s_ws,
  input  logic                    i2s_sd,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic [CNT_WIDTH-1:0]    slot_bits,
  output logic                    locked,
  output logic                    overflow,
  input  logic                    overflow_clear
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  logic sck_rise, ws_now, sd_now;

  state_t                  state_q;
  logic                    ws_prev_q, left_pend_q, valid_q, ovf_q;
  logic [CNT_WIDTH-1:0]    bitcnt_q, bitcnt_inc, slot_bits_q;
  logic [SAMPLE_WIDTH-1:0] shreg_q, word_d, left_word_q, out_left_q, out_right_q;
  logic [IDLE_W-1:0]       idle_q, idle_inc;
  logic                    boundary, timeout, publish, accept;

  i2s_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock      (clock),
    .reset      (reset),
    .sck_i      (i2s_sck),
    .ws_i       (i2s_ws),
    .sd_i       (i2s_sd),
    .sck_rise_o (sck_rise),
    .ws_now_o   (ws_now),
    .sd_now_o   (sd_now)
  );

  // Current bit dropped into its MSB-first slot; past SAMPLE_WIDTH it matches
  // no position, which is what truncates long slots.
  always_comb begin
    word_d = shreg_q;
    for (int i = 0; i < SAMPLE_WIDTH; i++)
      if (int'(bitcnt_q) == SAMPLE_WIDTH - 1 - i) word_d[i] = sd_now;
  end

  assign bitcnt_inc = (&bitcnt_q) ? bitcnt_q : bitcnt_q + 1'b1;
  assign idle_inc   = (idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1;
  // WS leads data by one bit: the edge where WS changes carries the old slot's LSB.
  assign boundary   = sck_rise && (ws_now != ws_prev_q);
  assign timeout    = !sck_rise && (idle_inc == IDLE_MAX);
  assign publish    = boundary && (state_q == SYNC) && (ws_prev_q != CH_LEFT) && left_pend_q;
  assign accept     = !valid_q || sample_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      ws_prev_q   <= 1'b0;
      left_pend_q <= 1'b0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      left_word_q <= '0;
      slot_bits_q <= '0;
      idle_q      <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      idle_q <= sck_rise ? '0 : idle_inc;

      if (sck_rise) begin
        ws_prev_q <= ws_now;
        if (boundary) begin
          bitcnt_q <= '0;
          shreg_q  <= '0;
        end else begin
          bitcnt_q <= bitcnt_inc;
          shreg_q  <= word_d;
        end
      end

      if (boundary) begin
        if (state_q == HUNT) begin
          state_q     <= SYNC;
          left_pend_q <= 1'b0;
        end else begin
          slot_bits_q <= bitcnt_inc;
          if (ws_prev_q == CH_LEFT) begin
            left_word_q <= word_d;
            left_pend_q <= 1'b1;
          end else begin
            // Right slot closes: either publishes or was a partial frame.
            left_pend_q <= 1'b0;
          end
        end
      end else if (timeout) begin
        state_q     <= HUNT;
        left_pend_q <= 1'b0;
      end

      // A publish in the transfer cycle reloads and keeps valid high.
      if (publish && accept) begin
        out_left_q  <= left_word_q;
        out_right_q <= word_d;
        valid_q     <= 1'b1;
      end else if (valid_q && sample_ready) begin
        valid_q <= 1'b0;
      end

      // Set is written last so a simultaneous drop beats the clear.
      if (overflow_clear) ovf_q <= 1'b0;
      if (publish && !accept) ovf_q <= 1'b1;
    end
  end

  assign sample_valid = valid_q;
  assign sample_left  = out_left_q;
  assign sample_right = out_right_q;
  assign slot_bits    = slot_bits_q;
  assign locked       = (state_q == SYNC);
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_i2s_receiver.sv
module tb_i2s_receiver;

  localparam int SW = 16;
  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          i2s_sck = 1'b0, i2s_ws = 1'b0, i2s_sd = 1'b0;
  logic          sample_ready = 1'b0, overflow_clear = 1'b0;
  logic          sample_valid, locked, overflow;
  logic [SW-1:0] sample_left, sample_right;
  logic [CW-1:0] slot_bits;

  int errors = 0;
  int checks = 0;
  int sck_half = 73;

  i2s_receiver dut (
    .clock          (clock),
    .reset          (reset),
    .i2s_sck        (i2s_sck),
    .i2s_ws         (i2s_ws),
    .i2s_sd         (i2s_sd),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .slot_bits      (slot_bits),
    .locked         (locked),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  always #10 clock = ~clock;

  typedef struct { logic [15:0] l; logic [15:0] r; logic [5:0] bits; } pair_t;
  pair_t got[$];

  // Records every completed valid/ready transfer.
  always @(negedge clock)
    if (!reset && sample_valid && sample_ready)
      got.push_back('{sample_left, sample_right, slot_bits});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic getbit(input logic [63:0] w, input int idx);
    return (idx >= 0 && idx < 64) ? w[idx[5:0]] : 1'b0;
  endfunction

  // Reference: the k-th transmitted bit lands in the k-th MSB; missing bits are 0.
  function automatic logic [15:0] model_word(input logic [63:0] w, input int n);
    logic [15:0] r = '0;
    for (int k = 0; k < 16; k++) r = {r[14:0], (k < n) ? getbit(w, n - 1 - k) : 1'b0};
    return r;
  endfunction

  function automatic logic [5:0] model_bits(input int n);
    return (n > 63) ? 6'd63 : 6'(n);
  endfunction

  task automatic send_bit(input logic ws, input logic sd);
    i2s_ws = ws; i2s_sd = sd;
    #(sck_half) i2s_sck = 1'b1;
    #(sck_half) i2s_sck = 1'b0;
  endtask

  // Bits [from,to) of an n-bit slot; the last bit carries the next channel's WS.
  task automatic send_slot(input logic ch, input logic [63:0] w, input int n,
                           input int from, input int to);
    for (int j = from; j < to; j++) send_bit((j == n - 1) ? ~ch : ch, getbit(w, n - 1 - j));
  endtask

  task automatic send_frame(input int n, input logic [63:0] l, input logic [63:0] r);
    send_slot(1'b0, l, n, 0, n);
    send_slot(1'b1, r, n, 0, n);
  endtask

  task automatic settle();
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic expect_one(input string name, input logic [15:0] el,
                            input logic [15:0] er, input logic [5:0] eb);
    pair_t p;
    chk({name, "_count"}, got.size(), 1);
    if (got.size() > 0) begin
      p = got.pop_front();
      chk({name, "_left"}, p.l, el);
      chk({name, "_right"}, p.r, er);
      chk({name, "_bits"}, p.bits, eb);
    end
    got.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, sample_valid, 0);
    chk({name, "_left"}, sample_left, 0);
    chk({name, "_right"}, sample_right, 0);
    chk({name, "_bits"}, slot_bits, 0);
    chk({name, "_locked"}, locked, 0);
    chk({name, "_overflow"}, overflow, 0);
  endtask

  typedef struct {
    int n; logic [63:0] l; logic [63:0] r;
    logic [15:0] el; logic [15:0] er; logic [5:0] eb;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int n;
    logic [63:0] l, r;

    vecs[0] = '{16, 64'hA5C3, 64'h1234, 16'hA5C3, 16'h1234, 6'd16};
    vecs[1] = '{32, 64'h8001FFFF, 64'h7FFE0000, 16'h8001, 16'h7FFE, 6'd32};
    vecs[2] = '{12, 64'hABC, 64'h555, 16'hABC0, 16'h5550, 6'd12};
    vecs[3] = '{1, 64'h1, 64'h0, 16'h8000, 16'h0000, 6'd1};
    vecs[4] = '{70, 64'hFFC0_0000_0000_0001, 64'hAAAA_0000_0000_0000, 16'h03FF, 16'h02AA, 6'd63};

    // Reset state
    repeat (3) @(posedge clock);
    #1 chk_all_zero("reset");
    reset = 1'b0;
    sample_ready = 1'b1;

    // Dummy frame at ~1.5 MHz SCK: locks, delivers nothing
    sck_half = 333;
    send_frame(16, 64'hFFFF, 64'hFFFF);
    settle();
    chk("dummy_dropped", got.size(), 0);
    chk("dummy_locked", locked, 1);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      sck_half = (i == 0) ? 333 : 73;
      send_frame(vecs[i].n, vecs[i].l, vecs[i].r);
      settle();
      expect_one($sformatf("vec%0d", i), vecs[i].el, vecs[i].er, vecs[i].eb);
      chk($sformatf("vec%0d_locked", i), locked, 1);
    end

    // Random widths and data against the model
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(1, 70);
      l = {$urandom, $urandom};
      r = {$urandom, $urandom};
      send_frame(n, l, r);
      settle();
      expect_one($sformatf("rnd%0d", i), model_word(l, n), model_word(r, n), model_bits(n));
    end

    // Backpressure across 3 frames
    @(posedge clock); #1 sample_ready = 1'b0;
    send_frame(16, 64'h1111, 64'h2222);
    send_frame(16, 64'h3333, 64'h4444);
    send_frame(16, 64'h5555, 64'h6666);
    settle();
    chk("bp_valid", sample_valid, 1);
    chk("bp_left", sample_left, 16'h1111);
    chk("bp_right", sample_right, 16'h2222);
    chk("bp_overflow", overflow, 1);
    @(posedge clock); #1 overflow_clear = 1'b1;
    @(posedge clock); #1 overflow_clear = 1'b0;
    chk("bp_ovf_cleared", overflow, 0);
    chk("bp_still_valid", sample_valid, 1);
    sample_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_valid_drop", sample_valid, 0);
    expect_one("bp_xfer", 16'h1111, 16'h2222, 6'd16);

    // SCK stalls mid right slot: lock lost, partial frame never delivered
    send_slot(1'b0, 64'hAAAA, 16, 0, 16);
    send_slot(1'b1, 64'h5555, 16, 0, 8);
    repeat (1000) @(posedge clock);
    #1 chk("to_still_locked", locked, 1);
    repeat (60) @(posedge clock);
    #1 chk("to_unlocked", locked, 0);
    chk("to_no_pair", got.size(), 0);
    send_slot(1'b1, 64'h5555, 16, 8, 16);
    settle();
    chk("to_relock", locked, 1);
    chk("to_partial_dropped", got.size(), 0);
    send_frame(16, 64'h0F0F, 64'hF0F0);
    settle();
    expect_one("to_frame", 16'h0F0F, 16'hF0F0, 6'd16);

    // Reset during the 9th bit of a left slot with a held pair and overflow
    sample_ready = 1'b0;
    send_frame(16, 64'h1111, 64'h2222);
    send_frame(16, 64'h3333, 64'h4444);
    settle();
    chk("pre_rst_valid", sample_valid, 1);
    chk("pre_rst_overflow", overflow, 1);
    send_slot(1'b0, 64'hBEEF, 16, 0, 8);
    i2s_ws = 1'b0; i2s_sd = getbit(64'hBEEF, 7);
    #(sck_half) reset = 1'b1;
    #3 chk_all_zero("midrst");
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    sample_ready = 1'b1;
    got.delete();
    send_slot(1'b0, 64'hBEEF, 16, 8, 16);
    send_slot(1'b1, 64'hCAFE, 16, 0, 16);
    settle();
    chk("rst_partial_dropped", got.size(), 0);
    chk("rst_relocked", locked, 1);
    send_frame(16, 64'h1357, 64'h2468);
    settle();
    expect_one("rst_frame", 16'h1357, 16'h2468, 6'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
